// File: rtl/dispatch_queue_if.sv
// Shared types and the packet/dispatch interface for the dispatch queue.

package dispatch_queue_pkg;
  localparam int unsigned ADDR_WIDTH = 32;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] imm;
  } instruction_t;

  // One stored slot: a compacted two-lane packet plus its branch prediction.
  typedef struct packed {
    logic [1:0]            valid;
    instruction_t          inst_0;
    instruction_t          inst_1;
    logic                  predict_taken;
    logic [ADDR_WIDTH-1:0] predict_target;
  } packet_t;
endpackage

interface dispatch_queue_if #(
  parameter int unsigned ROB_WIDTH = 4
);
  import dispatch_queue_pkg::*;

  logic                  flush;
  logic [ROB_WIDTH-1:0]  flush_rob_tail;
  logic [1:0]            in_valid;
  instruction_t          in_instruction_0;
  instruction_t          in_instruction_1;
  logic                  in_predict_taken;
  logic [ADDR_WIDTH-1:0] in_predict_target;
  logic                  in_ready;
  logic [ROB_WIDTH:0]    rob_free_count;
  logic                  busy_alu;
  logic                  busy_lsu;
  logic                  busy_branch;
  logic [1:0]            rename_valid;
  instruction_t          rename_instruction_0;
  instruction_t          rename_instruction_1;
  logic [ROB_WIDTH-1:0]  rob_id_0;
  logic [ROB_WIDTH-1:0]  rob_id_1;
  logic                  predict_taken;
  logic [ADDR_WIDTH-1:0] predict_target;
  logic                  stall_dispatch;
  logic [1:0]            rob_alloc;

  modport master (
    output flush, flush_rob_tail, in_valid, in_instruction_0, in_instruction_1,
           in_predict_taken, in_predict_target, rob_free_count,
           busy_alu, busy_lsu, busy_branch,
    input  in_ready, rename_valid, rename_instruction_0, rename_instruction_1,
           rob_id_0, rob_id_1, predict_taken, predict_target,
           stall_dispatch, rob_alloc
  );

  modport slave (
    input  flush, flush_rob_tail, in_valid, in_instruction_0, in_instruction_1,
           in_predict_taken, in_predict_target, rob_free_count,
           busy_alu, busy_lsu, busy_branch,
    output in_ready, rename_valid, rename_instruction_0, rename_instruction_1,
           rob_id_0, rob_id_1, predict_taken, predict_target,
           stall_dispatch, rob_alloc
  );
endinterface

// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers renamed 2-instruction packets and hands the head
// packet to dispatch once reservation stations and ROB space allow.

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned PKT_DEPTH = 4,
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  dispatch_queue_if.slave dq
);

  localparam int unsigned PTR_W  = $clog2(PKT_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FREE_W = ROB_WIDTH + 1;

  if (PKT_DEPTH < 2 || (PKT_DEPTH & (PKT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("PKT_DEPTH must be a power of two and at least 2");
  end

  packet_t              mem_q [PKT_DEPTH];
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ROB_WIDTH-1:0] rob_tail_q;

  packet_t              head_pkt_c;
  packet_t              in_pkt_c;
  logic                 empty_c;
  logic                 full_c;
  logic                 busy_c;
  logic                 stall_c;
  logic                 fire_c;
  logic                 enq_c;
  logic [1:0]           need_c;

  // Head/occupancy decode, dispatch and enqueue qualification, lane compaction.
  always_comb begin
    head_pkt_c = mem_q[head_q];
    empty_c    = (cnt_q == '0);
    full_c     = (cnt_q == CNT_W'(PKT_DEPTH));
    need_c     = 2'(head_pkt_c.valid[0]) + 2'(head_pkt_c.valid[1]);
    busy_c     = dq.busy_alu | dq.busy_lsu | dq.busy_branch;
    stall_c    = !empty_c && (busy_c || (dq.rob_free_count < FREE_W'(need_c)));
    fire_c     = !empty_c && !stall_c && !dq.flush;
    enq_c      = (dq.in_valid != 2'b00) && !full_c && !dq.flush;

    in_pkt_c                = '0;
    in_pkt_c.valid          = (dq.in_valid == 2'b10) ? 2'b01 : dq.in_valid;
    in_pkt_c.inst_0         = (dq.in_valid == 2'b10) ? dq.in_instruction_1
                                                     : dq.in_instruction_0;
    in_pkt_c.inst_1         = dq.in_instruction_1;
    in_pkt_c.predict_taken  = dq.in_predict_taken;
    in_pkt_c.predict_target = dq.in_predict_target;
  end

  // Packet storage; written only at the tail on an accepted enqueue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(PKT_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq_c) begin
      mem_q[tail_ptr_q] <= in_pkt_c;
    end
  end

  // Pointers, occupancy and ROB tail; flush overrides enqueue and dispatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_ptr_q <= '0;
      cnt_q      <= '0;
      rob_tail_q <= '0;
    end else if (dq.flush) begin
      head_q     <= '0;
      tail_ptr_q <= '0;
      cnt_q      <= '0;
      rob_tail_q <= dq.flush_rob_tail;
    end else begin
      if (fire_c) begin
        head_q     <= PTR_W'(head_q + 1'b1);
        rob_tail_q <= ROB_WIDTH'(rob_tail_q + ROB_WIDTH'(need_c));
      end
      if (enq_c) begin
        tail_ptr_q <= PTR_W'(tail_ptr_q + 1'b1);
      end
      cnt_q <= CNT_W'(cnt_q + CNT_W'(enq_c) - CNT_W'(fire_c));
    end
  end

  // Head slot drives the rename side directly.
  assign dq.in_ready             = !full_c;
  assign dq.rename_valid         = empty_c ? 2'b00 : head_pkt_c.valid;
  assign dq.rename_instruction_0 = head_pkt_c.inst_0;
  assign dq.rename_instruction_1 = head_pkt_c.inst_1;
  assign dq.predict_taken        = head_pkt_c.predict_taken;
  assign dq.predict_target       = head_pkt_c.predict_target;
  assign dq.rob_id_0             = rob_tail_q;
  assign dq.rob_id_1             = ROB_WIDTH'(rob_tail_q + 1'b1);
  assign dq.stall_dispatch       = stall_c;
  assign dq.rob_alloc            = fire_c ? need_c : 2'b00;

endmodule

// File: tb/tb_dispatch_queue.sv
// Testbench for dispatch_queue: directed scenarios plus randomized traffic
// checked against a packet-queue reference model.

module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int RW    = 4;
  localparam int ROB_N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_queue_if #(.ROB_WIDTH(RW)) dq ();

  dispatch_queue #(.PKT_DEPTH(DEPTH), .ROB_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .dq  (dq)
  );

  typedef struct {
    logic [1:0]            v;
    instruction_t          i0;
    instruction_t          i1;
    logic                  tk;
    logic [ADDR_WIDTH-1:0] tg;
  } m_pkt_t;

  m_pkt_t m_q[$];
  int     m_tail;
  int     checks = 0;
  int     errors = 0;

  logic          e_ready;
  logic [1:0]    e_rv;
  logic          e_stall;
  logic          e_fire;
  logic [1:0]    e_alloc;
  logic [RW-1:0] e_id0;
  logic [RW-1:0] e_id1;
  int            e_need;

  function automatic instruction_t rnd_instr();
    return instruction_t'($urandom);
  endfunction

  // Expected outputs from the model state and the currently driven inputs.
  task automatic model_eval();
    e_ready = (m_q.size() < DEPTH);
    e_rv    = 2'b00;
    e_stall = 1'b0;
    e_need  = 0;
    if (m_q.size() > 0) begin
      e_rv    = m_q[0].v;
      e_need  = (m_q[0].v == 2'b11) ? 2 : 1;
      e_stall = dq.busy_alu || dq.busy_lsu || dq.busy_branch ||
                (int'(dq.rob_free_count) < e_need);
    end
    e_fire  = (m_q.size() > 0) && !e_stall && !dq.flush;
    e_alloc = e_fire ? 2'(e_need) : 2'd0;
    e_id0   = RW'(m_tail);
    e_id1   = RW'((m_tail + 1) % ROB_N);
  endtask

  // Apply one clock edge to the model.
  task automatic model_update();
    m_pkt_t p;
    logic   acc;
    if (dq.flush) begin
      m_q.delete();
      m_tail = int'(dq.flush_rob_tail);
    end else begin
      acc = (dq.in_valid != 2'b00) && e_ready;
      if (e_fire) begin
        void'(m_q.pop_front());
        m_tail = (m_tail + e_need) % ROB_N;
      end
      if (acc) begin
        p.v  = (dq.in_valid == 2'b10) ? 2'b01 : dq.in_valid;
        p.i0 = (dq.in_valid == 2'b10) ? dq.in_instruction_1 : dq.in_instruction_0;
        p.i1 = dq.in_instruction_1;
        p.tk = dq.in_predict_taken;
        p.tg = dq.in_predict_target;
        m_q.push_back(p);
      end
    end
  endtask

  task automatic idle();
    dq.flush             = 1'b0;
    dq.flush_rob_tail    = '0;
    dq.in_valid          = 2'b00;
    dq.in_instruction_0  = '0;
    dq.in_instruction_1  = '0;
    dq.in_predict_taken  = 1'b0;
    dq.in_predict_target = '0;
    dq.rob_free_count    = 5'd16;
    dq.busy_alu          = 1'b0;
    dq.busy_lsu          = 1'b0;
    dq.busy_branch       = 1'b0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic push_random(input logic [1:0] v);
    dq.in_valid          = v;
    dq.in_instruction_0  = rnd_instr();
    dq.in_instruction_1  = rnd_instr();
    dq.in_predict_taken  = 1'($urandom);
    dq.in_predict_target = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    dq.in_valid = 2'b11;
    dq.busy_alu = 1'b1;
    #3;
    checks++; if (dq.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", dq.in_ready); end
    checks++; if (dq.rename_valid !== 2'b00) begin errors++; $display("FAIL reset_rename_valid got %0b exp 00", dq.rename_valid); end
    checks++; if (dq.stall_dispatch !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", dq.stall_dispatch); end
    checks++; if (dq.rob_alloc !== 2'd0) begin errors++; $display("FAIL reset_rob_alloc got %0d exp 0", dq.rob_alloc); end
    checks++; if (dq.rob_id_0 !== 4'd0) begin errors++; $display("FAIL reset_rob_id_0 got %0d exp 0", dq.rob_id_0); end
    checks++; if (dq.rob_id_1 !== 4'd1) begin errors++; $display("FAIL reset_rob_id_1 got %0d exp 1", dq.rob_id_1); end
    idle();
    m_q.delete();
    m_tail = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    instruction_t a, b;
    push_random(2'b11);
    a = dq.in_instruction_0;
    b = dq.in_instruction_1;
    settle();
    checks++; if (dq.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b exp 1", dq.in_ready); end
    tick();
    idle();
    settle();
    checks++; if (dq.rename_valid !== 2'b11) begin errors++; $display("FAIL basic_rename_valid got %0b exp 11", dq.rename_valid); end
    checks++; if (dq.rob_id_0 !== 4'd0) begin errors++; $display("FAIL basic_rob_id_0 got %0d exp 0", dq.rob_id_0); end
    checks++; if (dq.rob_id_1 !== 4'd1) begin errors++; $display("FAIL basic_rob_id_1 got %0d exp 1", dq.rob_id_1); end
    checks++; if (dq.rob_alloc !== 2'd2) begin errors++; $display("FAIL basic_rob_alloc got %0d exp 2", dq.rob_alloc); end
    checks++; if (dq.rename_instruction_0 !== a) begin errors++; $display("FAIL basic_inst0 got %h exp %h", dq.rename_instruction_0, a); end
    checks++; if (dq.rename_instruction_1 !== b) begin errors++; $display("FAIL basic_inst1 got %h exp %h", dq.rename_instruction_1, b); end
    tick();
    settle();
    checks++; if (dq.rob_id_0 !== 4'd2) begin errors++; $display("FAIL basic_tail_after got %0d exp 2", dq.rob_id_0); end
    checks++; if (dq.rename_valid !== 2'b00) begin errors++; $display("FAIL basic_empty_after got %0b exp 00", dq.rename_valid); end
  endtask

  task automatic test_full_stall();
    idle();
    dq.busy_lsu = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_random((k % 2 == 1) ? 2'b01 : 2'b11);
      settle();
      checks++; if (dq.in_ready !== logic'(k < 4)) begin errors++; $display("FAIL full_in_ready k=%0d got %0b exp %0b", k, dq.in_ready, k < 4); end
      if (k > 0) begin
        checks++; if (dq.stall_dispatch !== 1'b1) begin errors++; $display("FAIL full_stall k=%0d got %0b exp 1", k, dq.stall_dispatch); end
      end
      tick();
    end
    dq.in_valid = 2'b00;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (dq.stall_dispatch !== 1'b1) begin errors++; $display("FAIL hold_stall c=%0d got %0b exp 1", c, dq.stall_dispatch); end
      checks++; if (dq.rename_valid !== m_q[0].v) begin errors++; $display("FAIL hold_valid c=%0d got %0b exp %0b", c, dq.rename_valid, m_q[0].v); end
      checks++; if (dq.rename_instruction_0 !== m_q[0].i0) begin errors++; $display("FAIL hold_inst0 c=%0d got %h exp %h", c, dq.rename_instruction_0, m_q[0].i0); end
      checks++; if (dq.predict_target !== m_q[0].tg) begin errors++; $display("FAIL hold_target c=%0d got %h exp %h", c, dq.predict_target, m_q[0].tg); end
      checks++; if (dq.rob_alloc !== 2'd0) begin errors++; $display("FAIL hold_alloc c=%0d got %0d exp 0", c, dq.rob_alloc); end
      checks++; if (dq.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready c=%0d got %0b exp 0", c, dq.in_ready); end
      tick();
    end
    dq.busy_lsu = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (dq.rob_alloc !== ((k % 2 == 1) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL drain_alloc k=%0d got %0d exp %0d", k, dq.rob_alloc, (k % 2 == 1) ? 1 : 2); end
      checks++; if (dq.rob_id_0 !== e_id0) begin errors++; $display("FAIL drain_rob_id_0 k=%0d got %0d exp %0d", k, dq.rob_id_0, e_id0); end
      tick();
    end
    settle();
    checks++; if (dq.rename_valid !== 2'b00) begin errors++; $display("FAIL drain_empty got %0b exp 00", dq.rename_valid); end
  endtask

  task automatic test_rob_wrap();
    idle();
    dq.flush = 1'b1;
    dq.flush_rob_tail = 4'd15;
    tick();
    idle();
    push_random(2'b11);
    tick();
    idle();
    settle();
    checks++; if (dq.rob_id_0 !== 4'd15) begin errors++; $display("FAIL wrap_rob_id_0 got %0d exp 15", dq.rob_id_0); end
    checks++; if (dq.rob_id_1 !== 4'd0) begin errors++; $display("FAIL wrap_rob_id_1 got %0d exp 0", dq.rob_id_1); end
    checks++; if (dq.rob_alloc !== 2'd2) begin errors++; $display("FAIL wrap_alloc got %0d exp 2", dq.rob_alloc); end
    tick();
    settle();
    checks++; if (dq.rob_id_0 !== 4'd1) begin errors++; $display("FAIL wrap_tail_after got %0d exp 1", dq.rob_id_0); end
  endtask

  task automatic test_compaction();
    instruction_t b;
    idle();
    push_random(2'b10);
    b = dq.in_instruction_1;
    dq.in_instruction_0 = ~b;
    tick();
    idle();
    settle();
    checks++; if (dq.rename_valid !== 2'b01) begin errors++; $display("FAIL compact_valid got %0b exp 01", dq.rename_valid); end
    checks++; if (dq.rename_instruction_0 !== b) begin errors++; $display("FAIL compact_inst0 got %h exp %h", dq.rename_instruction_0, b); end
    checks++; if (dq.rob_alloc !== 2'd1) begin errors++; $display("FAIL compact_alloc got %0d exp 1", dq.rob_alloc); end
    tick();
  endtask

  task automatic test_rob_credit();
    idle();
    dq.rob_free_count = 5'd1;
    push_random(2'b11);
    tick();
    dq.in_valid = 2'b00;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (dq.stall_dispatch !== 1'b1) begin errors++; $display("FAIL credit_stall c=%0d got %0b exp 1", c, dq.stall_dispatch); end
      checks++; if (dq.rob_alloc !== 2'd0) begin errors++; $display("FAIL credit_alloc c=%0d got %0d exp 0", c, dq.rob_alloc); end
      checks++; if (dq.rename_valid !== 2'b11) begin errors++; $display("FAIL credit_valid c=%0d got %0b exp 11", c, dq.rename_valid); end
      tick();
    end
    dq.rob_free_count = 5'd2;
    settle();
    checks++; if (dq.stall_dispatch !== 1'b0) begin errors++; $display("FAIL credit_release_stall got %0b exp 0", dq.stall_dispatch); end
    checks++; if (dq.rob_alloc !== 2'd2) begin errors++; $display("FAIL credit_release_alloc got %0d exp 2", dq.rob_alloc); end
    tick();
    settle();
    checks++; if (dq.rename_valid !== 2'b00) begin errors++; $display("FAIL credit_empty got %0b exp 00", dq.rename_valid); end
  endtask

  task automatic test_flush();
    idle();
    dq.busy_alu = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_random(2'b11);
      tick();
    end
    push_random(2'b11);
    dq.flush = 1'b1;
    dq.flush_rob_tail = 4'd9;
    tick();
    idle();
    settle();
    checks++; if (dq.rename_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %0b exp 00", dq.rename_valid); end
    checks++; if (dq.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b exp 1", dq.in_ready); end
    checks++; if (dq.stall_dispatch !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b exp 0", dq.stall_dispatch); end
    push_random(2'b01);
    tick();
    idle();
    settle();
    checks++; if (dq.rob_id_0 !== 4'd9) begin errors++; $display("FAIL flush_rob_id_0 got %0d exp 9", dq.rob_id_0); end
    checks++; if (dq.rob_alloc !== 2'd1) begin errors++; $display("FAIL flush_alloc got %0d exp 1", dq.rob_alloc); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    dq.busy_branch = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_random(2'b11);
      tick();
    end
    dq.in_valid = 2'b00;
    #2;
    rst = 1'b0;
    dq.busy_branch = 1'b0;
    #1;
    checks++; if (dq.rename_valid !== 2'b00) begin errors++; $display("FAIL rstmid_valid got %0b exp 00", dq.rename_valid); end
    checks++; if (dq.rob_alloc !== 2'd0) begin errors++; $display("FAIL rstmid_alloc got %0d exp 0", dq.rob_alloc); end
    checks++; if (dq.rob_id_0 !== 4'd0) begin errors++; $display("FAIL rstmid_rob_id_0 got %0d exp 0", dq.rob_id_0); end
    checks++; if (dq.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b exp 1", dq.in_ready); end
    m_q.delete();
    m_tail = 0;
    @(posedge clk);
    #1;
    checks++; if (dq.rob_alloc !== 2'd0) begin errors++; $display("FAIL rstmid_alloc_edge got %0d exp 0", dq.rob_alloc); end
    @(negedge clk);
    rst = 1'b1;
    settle();
    checks++; if (dq.rename_valid !== 2'b00) begin errors++; $display("FAIL rstmid_discard got %0b exp 00", dq.rename_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      push_random(2'($urandom));
      dq.busy_alu       = ($urandom_range(0, 5) == 0);
      dq.busy_lsu       = ($urandom_range(0, 5) == 0);
      dq.busy_branch    = ($urandom_range(0, 5) == 0);
      dq.rob_free_count = 5'($urandom_range(0, 16));
      dq.flush          = ($urandom_range(0, 24) == 0);
      dq.flush_rob_tail = 4'($urandom);
      settle();
      checks++; if (dq.in_ready !== e_ready) begin errors++; $display("FAIL rnd_in_ready n=%0d got %0b exp %0b", n, dq.in_ready, e_ready); end
      checks++; if (dq.rename_valid !== e_rv) begin errors++; $display("FAIL rnd_valid n=%0d got %0b exp %0b", n, dq.rename_valid, e_rv); end
      checks++; if (dq.stall_dispatch !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %0b exp %0b", n, dq.stall_dispatch, e_stall); end
      checks++; if (dq.rob_alloc !== e_alloc) begin errors++; $display("FAIL rnd_alloc n=%0d got %0d exp %0d", n, dq.rob_alloc, e_alloc); end
      checks++; if (dq.rob_id_0 !== e_id0) begin errors++; $display("FAIL rnd_rob_id_0 n=%0d got %0d exp %0d", n, dq.rob_id_0, e_id0); end
      checks++; if (dq.rob_id_1 !== e_id1) begin errors++; $display("FAIL rnd_rob_id_1 n=%0d got %0d exp %0d", n, dq.rob_id_1, e_id1); end
      if (m_q.size() > 0) begin
        checks++; if (dq.rename_instruction_0 !== m_q[0].i0) begin errors++; $display("FAIL rnd_inst0 n=%0d got %h exp %h", n, dq.rename_instruction_0, m_q[0].i0); end
        checks++; if (dq.predict_taken !== m_q[0].tk) begin errors++; $display("FAIL rnd_taken n=%0d got %0b exp %0b", n, dq.predict_taken, m_q[0].tk); end
        checks++; if (dq.predict_target !== m_q[0].tg) begin errors++; $display("FAIL rnd_target n=%0d got %h exp %h", n, dq.predict_target, m_q[0].tg); end
        if (m_q[0].v == 2'b11) begin
          checks++; if (dq.rename_instruction_1 !== m_q[0].i1) begin errors++; $display("FAIL rnd_inst1 n=%0d got %h exp %h", n, dq.rename_instruction_1, m_q[0].i1); end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_stall();
    test_rob_wrap();
    test_compaction();
    test_rob_credit();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
